// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready
// result side. ADD, SUB, OR, AND and illegal opcodes finish one cycle after
// accept. MUL is an optional iterative shift-add multiplier taking WIDTH cycles.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   - opcode 100 runs the iterative multiplier through BUSY
//   undefined - no multiplier datapath; opcode 100 is reported as illegal
//
// Ports
//   clk_i                    single clock, rising edge
//   rst_n_i                  asynchronous active-low reset
//   valid_i / ready_o        request handshake (ready_o high only in IDLE)
//   operation_i              000 ADD, 001 SUB, 010 OR, 011 AND, 100 MUL
//   operand1_i, operand2_i   unsigned operands
//   carry_in                 carry for ADD, borrow for SUB
//   valid_o / ready_i        result handshake (valid_o high only in DONE)
//   result_o, result_hi_o    result low word, MUL high word (0 otherwise)
//   zero, carry_out, ovf_o, err_o   status flags
//
// state | meaning
// IDLE  | waiting for a request, ready_o = 1
// BUSY  | multiplier iterating, one multiplier bit per cycle
// DONE  | result and flags held, valid_o = 1 until ready_i

module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       operation_i,
    input  logic [WIDTH-1:0] operand1_i,
    input  logic [WIDTH-1:0] operand2_i,
    input  logic             carry_in,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero,
    output logic             carry_out,
    output logic             ovf_o,
    output logic             err_o
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Single-cycle datapath, evaluated straight from the inputs on the accept edge.
    // Both are WIDTH+1 wide: the top bit is the carry for ADD and the borrow for
    // SUB (a negative difference wraps with bit WIDTH set).
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_err;

    assign add_full = {1'b0, operand1_i} + {1'b0, operand2_i} + {{WIDTH{1'b0}}, carry_in};
    assign sub_full = {1'b0, operand1_i} - {1'b0, operand2_i} - {{WIDTH{1'b0}}, carry_in};

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (operation_i)
            OP_ADD: begin
                alu_res  = add_full[WIDTH-1:0];
                alu_cout = add_full[WIDTH];
                alu_ovf  = (operand1_i[WIDTH-1] == operand2_i[WIDTH-1]) &&
                           (add_full[WIDTH-1] != operand1_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res  = sub_full[WIDTH-1:0];
                alu_cout = sub_full[WIDTH];
                alu_ovf  = (operand1_i[WIDTH-1] != operand2_i[WIDTH-1]) &&
                           (sub_full[WIDTH-1] != operand1_i[WIDTH-1]);
            end
            OP_OR:   alu_res = operand1_i | operand2_i;
            OP_AND:  alu_res = operand1_i & operand2_i;
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam int         CW     = $clog2(WIDTH);

    // Multiplicand shifts left and multiplier shifts right each BUSY cycle; the
    // down-counter reaching zero marks the last partial product.
    logic [CW-1:0]      mul_cnt;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic [2*WIDTH-1:0] mul_acc_next;

    assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            ready_o     <= 1'b1;
            valid_o     <= 1'b0;
            result_o    <= '0;
            result_hi_o <= '0;
            zero        <= 1'b0;
            carry_out   <= 1'b0;
            ovf_o       <= 1'b0;
            err_o       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mul_cnt     <= '0;
            mul_acc     <= '0;
            mul_mcand   <= '0;
            mul_mplier  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        ready_o <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        if (operation_i == OP_MUL) begin
                            mul_cnt    <= CW'(WIDTH - 1);
                            mul_acc    <= '0;
                            mul_mcand  <= {{WIDTH{1'b0}}, operand1_i};
                            mul_mplier <= operand2_i;
                            state      <= BUSY;
                        end else
`endif
                        begin
                            result_o    <= alu_res;
                            result_hi_o <= '0;
                            zero        <= (alu_res == '0);
                            carry_out   <= alu_cout;
                            ovf_o       <= alu_ovf;
                            err_o       <= alu_err;
                            valid_o     <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                BUSY: begin
`ifdef ALU_SEQ_MUL_EN
                    mul_acc    <= mul_acc_next;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    if (mul_cnt == '0) begin
                        result_o    <= mul_acc_next[WIDTH-1:0];
                        result_hi_o <= mul_acc_next[2*WIDTH-1:WIDTH];
                        zero        <= (mul_acc_next == '0);
                        carry_out   <= |mul_acc_next[2*WIDTH-1:WIDTH];
                        ovf_o       <= 1'b0;
                        err_o       <= 1'b0;
                        valid_o     <= 1'b1;
                        state       <= DONE;
                    end else begin
                        mul_cnt <= mul_cnt - 1'b1;
                    end
`else
                    // Unreachable without the multiplier; recover to IDLE.
                    ready_o <= 1'b1;
                    state   <= IDLE;
`endif
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
